shift_and_subtract_binary_divider: RTL and testbench

Sequential unsigned restoring divider, the inverse of the team's shift-and-add multiplier. It computes quotient and remainder of an M-bit dividend by an N-bit divisor. It resolves one quotient bit per clock, MSB first, using a start/done handshake. Downstream arithmetic datapaths use it wherever the multiplier's product must be reduced back.

---
 rtl/shift_and_subtract_binary_divider.sv | 139 +++++++++++++
 tb/tb_shift_and_subtract_binary_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_and_subtract_binary_divider.sv
// rtl/shift_and_subtract_binary_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module shift_and_subtract_binary_divider #(
   parameter int m = 8,
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [m-1:0] A,
   input  logic [n-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [m-1:0] Q,
   output logic [n-1:0] R,
   output logic         div_by_zero
);

   localparam int CW = (m > 1) ? $clog2(m) : 1;

   typedef enum logic {IDLE, CALC} state_t;

   state_t state_q, state_d;

   logic [m-1:0]  d_q, d_d;
   logic [n-1:0]  bq_q, bq_d;
   logic [n:0]    p_q, p_d;
   logic [m-1:0]  qs_q, qs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [m-1:0]  q_q, q_d;
   logic [n-1:0]  r_q, r_d;
   logic          done_q, done_d;
   logic          dz_q, dz_d;

   logic [n:0]    t;
   logic [n:0]    diff;
   logic [n:0]    p_next;
   logic          ge;
   logic [m-1:0]  qs_shift;
   logic          last;
   logic          accept_div;
   logic          accept_zero;

   // Trial subtraction; a set top bit of P would mean T already exceeds any divisor.
   assign t        = {p_q[n-1:0], d_q[m-1]};
   assign ge       = p_q[n] | (t >= {1'b0, bq_q});
   assign diff     = t - {1'b0, bq_q};
   assign p_next   = ge ? diff : t;
   assign qs_shift = (qs_q << 1) | m'(ge);
   assign last     = (cnt_q == '0);

   assign accept_div  = (state_q == IDLE) && start && (B != '0);
   assign accept_zero = (state_q == IDLE) && start && (B == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_div) state_d = CALC;
         CALC:    if (last)       state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == CALC);
   end

   always_comb begin
      d_d    = d_q;
      bq_d   = bq_q;
      p_d    = p_q;
      qs_d   = qs_q;
      cnt_d  = cnt_q;
      q_d    = q_q;
      r_d    = r_q;
      dz_d   = dz_q;
      done_d = 1'b0;
      if (accept_div) begin
         d_d   = A;
         bq_d  = B;
         p_d   = '0;
         qs_d  = '0;
         cnt_d = CW'(m - 1);
         dz_d  = 1'b0;
      end else if (accept_zero) begin
         q_d    = '1;
         r_d    = '0;
         dz_d   = 1'b1;
         done_d = 1'b1;
      end else if (state_q == CALC) begin
         p_d   = p_next;
         qs_d  = qs_shift;
         d_d   = d_q << 1;
         cnt_d = cnt_q - CW'(1);
         if (last) begin
            q_d    = qs_shift;
            r_d    = p_next[n-1:0];
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         d_q    <= '0;
         bq_q   <= '0;
         p_q    <= '0;
         qs_q   <= '0;
         cnt_q  <= '0;
         q_q    <= '0;
         r_q    <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         d_q    <= d_d;
         bq_q   <= bq_d;
         p_q    <= p_d;
         qs_q   <= qs_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
         r_q    <= r_d;
         done_q <= done_d;
         dz_q   <= dz_d;
      end
   end

   assign done        = done_q;
   assign Q           = q_q;
   assign R           = r_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// tb/tb_shift_and_subtract_binary_divider.sv - directed table-driven bench for the restoring divider
module tb_shift_and_subtract_binary_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic [7:0] Q;
   logic [7:0] R;
   logic       div_by_zero;

   int checks   = 0;
   int failures = 0;

   shift_and_subtract_binary_divider #(.m(8), .n(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int dz;
      int edges;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns edges counted after the accepting edge until done, and busy cycles seen.
   task automatic wait_done(output int edges, output int bcnt);
      edges = 0;
      bcnt  = 0;
      while (!done && edges < 40) begin
         if (busy) bcnt++;
         tick();
         edges++;
      end
   endtask

   task automatic issue(input int a, input int b);
      start = 1'b1;
      A     = 8'(a);
      B     = 8'(b);
      tick();
      start = 1'b0;
   endtask

   initial begin
      int edges, bcnt, seen;
      rst   = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;

      vecs[0] = '{200,   7,  28, 4, 0, 8};
      vecs[1] = '{255,   1, 255, 0, 0, 8};
      vecs[2] = '{  5,   9,   0, 5, 0, 8};
      vecs[3] = '{255, 255,   1, 0, 0, 8};
      vecs[4] = '{  0,  13,   0, 0, 0, 8};
      vecs[5] = '{100,   0, 255, 0, 1, 0};
      vecs[6] = '{100,  10,  10, 0, 0, 8};
      vecs[7] = '{128,   3,  42, 2, 0, 8};
      vecs[8] = '{  1,   1,   1, 0, 0, 8};
      vecs[9] = '{254,  16,  15, 14, 0, 8};

      // Reset then idle
      tick();
      tick();
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (Q != 0 || R != 0 || done || busy || div_by_zero) seen++;
      end
      check("idle_after_reset_nonzero_cycles", seen, 0);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].a, vecs[i].b);
         wait_done(edges, bcnt);
         check($sformatf("v%0d_edges", i), edges, vecs[i].edges);
         check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].edges);
         check($sformatf("v%0d_Q", i), int'(Q), vecs[i].q);
         check($sformatf("v%0d_R", i), int'(R), vecs[i].r);
         check($sformatf("v%0d_dz", i), int'(div_by_zero), vecs[i].dz);
         check($sformatf("v%0d_busy_with_done", i), int'(busy), 0);
         tick();
         check($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
         check($sformatf("v%0d_Q_held", i), int'(Q), vecs[i].q);
      end

      // Ignored start and input churn during CALC, then back-to-back start in the done cycle
      issue(200, 7);
      edges = 0;
      for (int c = 1; c <= 30 && !done; c++) begin
         A     = 8'($urandom);
         B     = 8'($urandom);
         start = (c == 3);
         if (c == 3) begin
            A = 8'd9;
            B = 8'd3;
         end
         tick();
         edges = c;
      end
      start = 1'b0;
      check("churn_edges", edges, 8);
      check("churn_Q", int'(Q), 28);
      check("churn_R", int'(R), 4);
      issue(9, 3);
      check("b2b_Q_held_while_busy", int'(Q), 28);
      wait_done(edges, bcnt);
      check("b2b_edges", edges, 8);
      check("b2b_Q", int'(Q), 3);
      check("b2b_R", int'(R), 0);

      // Reset mid-operation
      tick();
      issue(200, 7);
      tick();
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_Q", int'(Q), 0);
      check("midrst_R", int'(R), 0);
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (done || busy) seen++;
      end
      check("midrst_no_late_done", seen, 0);
      issue(50, 6);
      wait_done(edges, bcnt);
      check("post_rst_edges", edges, 8);
      check("post_rst_Q", int'(Q), 8);
      check("post_rst_R", int'(R), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
